// File: rtl/serial_alu_8_pkg.sv
// serial_alu_8_pkg: shared constants for the bit-serial ALU
//    DEF_WIDTH        default operand/result width
//    IDLE/SHIFT/DONE  2-bit FSM state encoding
package serial_alu_8_pkg;
   localparam int DEF_WIDTH = 8;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;
endpackage

// File: rtl/serial_alu_8_fulladder.sv
// fullAdder: single-bit full adder for the serial datapath
//    a, b, c_in   addend bits and carry in
//    sum, c_out   sum bit and carry out
module fullAdder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);
   assign sum   = a ^ b ^ c_in;
   assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// File: rtl/serial_alu_8.sv
// serial_alu_8: bit-serial add/subtract, one bit per clock, LSB first
//    clk, rst                 clock, asynchronous active-high reset
//    start, op_sub, a, b      request, operation select (1 = a-b), operands
//    busy, done               operation in progress, one-cycle completion pulse
//    result, carry_out,       registered sum/difference, final carry (no-borrow on sub),
//    overflow, zero           signed overflow, result-is-zero
module serial_alu_8
   import serial_alu_8_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);
   localparam int CW = $clog2(WIDTH) + 1;
   logic [1:0]       state;
   logic [WIDTH-1:0] a_sr, b_sr, sh, nxt;
   logic [CW-1:0]    cnt;
   logic             cy, s, co, last;
   fullAdder u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .c_in (cy),
      .sum  (s),
      .c_out(co)
   );
   // sh is the working shift register; nxt is its value after this edge
   assign nxt  = {s, sh[WIDTH-1:1]};
   assign last = cnt == CW'(WIDTH - 1);
   assign busy = state == SHIFT;
   assign done = state == DONE;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         a_sr      <= '0;
         b_sr      <= '0;
         sh        <= '0;
         cnt       <= '0;
         cy        <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b1;
      end else begin
         case (state)
            IDLE: if (start) begin
               a_sr  <= a;
               b_sr  <= op_sub ? ~b : b;
               cy    <= op_sub;
               cnt   <= '0;
               state <= SHIFT;
            end
            SHIFT: begin
               sh   <= nxt;
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               cy   <= co;
               cnt  <= cnt + 1'b1;
               // cy still holds the carry into the MSB here, so overflow is cy ^ co
               if (last) begin
                  state     <= DONE;
                  result    <= nxt;
                  carry_out <= co;
                  overflow  <= cy ^ co;
                  zero      <= ~|nxt;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_alu_8.sv
// tb_serial_alu_8: randomized scoreboard bench for serial_alu_8
module tb_serial_alu_8;
   typedef struct packed {
      logic [7:0] r;
      logic       c;
      logic       v;
      logic       z;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       op_sub = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       busy, done, carry_out, overflow, zero;
   logic [7:0] result;
   int         checks = 0;
   int         errors = 0;
   exp_t       q[$];

   serial_alu_8 dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op_sub   (op_sub),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .carry_out(carry_out),
      .overflow (overflow),
      .zero     (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference: plain integer arithmetic on the operands
   function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic sub);
      exp_t e;
      int   u, sv;
      u   = sub ? int'(x) - int'(y) : int'(x) + int'(y);
      sv  = sub ? int'($signed(x)) - int'($signed(y)) : int'($signed(x)) + int'($signed(y));
      e.r = 8'(u);
      e.c = sub ? (x >= y) : (u > 255);
      e.v = (sv > 127) || (sv < -128);
      e.z = e.r == 8'h00;
      return e;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_result"}, result, 0);
      check({tag, "_carry"}, carry_out, 0);
      check({tag, "_ovf"}, overflow, 0);
      check({tag, "_zero"}, zero, 1);
   endtask

   // issue one op; junk scrambles inputs while busy/done, intf re-asserts start at N+3
   task automatic issue(input logic [7:0] ai, input logic [7:0] bi, input logic si,
                        input bit junk, input bit intf);
      @(negedge clk);
      start = 1'b1; a = ai; b = bi; op_sub = si;
      @(posedge clk);
      q.push_back(model(ai, bi, si));
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         check("busy_shift", busy, 1);
         check("done_early", done, 0);
         start  = intf ? (i == 3) : (junk ? 1'($urandom) : 1'b0);
         a      = intf ? 8'hAA : 8'($urandom);
         b      = intf ? 8'h01 : 8'($urandom);
         op_sub = intf ? 1'b0 : 1'($urandom);
         @(posedge clk);
      end
      @(negedge clk);
      check("done_latency", done, 1);
      check("busy_in_done", busy, 0);
      start = junk ? 1'($urandom) : 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      @(posedge clk);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         check("busy_done_excl", busy & done, 0);
         if (done) begin
            if (q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("result", result, e.r);
               check("carry_out", carry_out, e.c);
               check("overflow", overflow, e.v);
               check("zero", zero, e.z);
            end
         end
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      issue(8'h05, 8'h03, 1'b0, 0, 0);
      issue(8'h7F, 8'h01, 1'b0, 0, 0);
      issue(8'hFF, 8'h01, 1'b0, 0, 0);
      issue(8'h00, 8'h01, 1'b1, 0, 0);
      issue(8'h80, 8'h01, 1'b1, 0, 0);
      issue(8'h10, 8'h20, 1'b0, 0, 1);
      @(negedge clk);
      start = 1'b1; a = 8'h33; b = 8'h44; op_sub = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1 check_reset_outputs("abort");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      issue(8'h02, 8'h02, 1'b0, 0, 0);
      for (int n = 0; n < 40; n++) issue(8'($urandom), 8'($urandom), 1'($urandom), 1, 0);
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      check("pending_expected", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
